// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - sprite geometry, shared types and row reader state encoding
package sprite_pkg;
    localparam int SPRITE_NUM = 16;
    localparam int SPRITE_W   = 32;
    localparam int SPRITE_H   = 32;
    // Byte-address width of one sprite; the read port addresses nibbles, one bit wider.
    localparam int SPRITE_ADDR_SIZE = $clog2(SPRITE_W * SPRITE_H / 2);
    localparam int ID_W  = $clog2(SPRITE_NUM);
    localparam int ROW_W = $clog2(SPRITE_H);
    localparam int COL_W = $clog2(SPRITE_W);

    typedef logic [ID_W-1:0]           sprite_id_t;
    typedef logic [SPRITE_ADDR_SIZE:0] sprite_addr_t;
    typedef logic [ROW_W-1:0]          row_t;
    typedef logic [COL_W-1:0]          col_t;

    typedef struct packed {
        logic [3:0] pix;
        logic       last;
    } pix_entry_t;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} row_state_e;

    function automatic sprite_addr_t row_addr(input row_t row, input col_t col);
        return sprite_addr_t'(row) * sprite_addr_t'(SPRITE_W) + sprite_addr_t'(col);
    endfunction
endpackage

// File: rtl/sync_fifo_small.sv
// rtl/sync_fifo_small.sv - small power-of-two synchronous FIFO with flush
module sync_fifo_small #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        pop_data,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;
endmodule

// File: rtl/sprite_row_reader.sv
// rtl/sprite_row_reader.sv - fetches one sprite row from sprite_storage and streams its pixels
module sprite_row_reader import sprite_pkg::*; #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ID_W-1:0]           req_select,
    input  logic [ROW_W-1:0]          req_row,
    input  logic                      req_flip,
    input  logic                      abort,
    output logic [ID_W-1:0]           r_select,
    output logic [SPRITE_ADDR_SIZE:0] r_addr,
    input  logic [3:0]                r_data,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic [3:0]                pix_data,
    output logic                      pix_last
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    row_state_e   state_q, state_d;
    sprite_id_t   sel_q, sel_d;
    row_t         row_q, row_d;
    logic         flip_q, flip_d;
    col_t         col_cnt_q, col_cnt_d;
    logic         inflight_q, inflight_d;
    logic         last_inflight_q, last_inflight_d;
    sprite_addr_t r_addr_q, r_addr_d;

    logic [CW-1:0] fifo_count;
    pix_entry_t    head, entry_in;
    logic          push, pop, issue, last_col;
    col_t          col;
    sprite_addr_t  addr_now;

    always_comb begin
        pix_valid = (fifo_count != '0);
        pix_data  = head.pix;
        pix_last  = pix_valid && head.last;
        pop       = pix_valid && pix_ready;
        push      = inflight_q && !abort;
        last_col  = (col_cnt_q == col_t'(SPRITE_W - 1));
        col       = flip_q ? col_t'(SPRITE_W - 1) - col_cnt_q : col_cnt_q;
        addr_now  = row_addr(row_q, col);
        // Crediting this cycle's pop keeps one read per cycle flowing with a 2-entry FIFO.
        issue     = reset && !abort && (state_q == FETCH)
                    && (int'(fifo_count) + int'(inflight_q) - int'(pop) < FIFO_DEPTH);
        r_addr    = issue ? addr_now : r_addr_q;
        r_select  = sel_q;
        req_ready = (state_q == IDLE);
        entry_in.pix  = r_data;
        entry_in.last = last_inflight_q;

        state_d         = state_q;
        sel_d           = sel_q;
        row_d           = row_q;
        flip_d          = flip_q;
        col_cnt_d       = col_cnt_q;
        inflight_d      = issue;
        last_inflight_d = issue && last_col;
        r_addr_d        = r_addr;

        case (state_q)
            IDLE: begin
                if (req_valid && !abort) begin
                    sel_d     = req_select;
                    row_d     = req_row;
                    flip_d    = req_flip;
                    col_cnt_d = '0;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                if (issue) begin
                    col_cnt_d = col_cnt_q + 1'b1;
                    if (last_col) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_count == '0 && !inflight_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= IDLE;
            sel_q           <= '0;
            row_q           <= '0;
            flip_q          <= 1'b0;
            col_cnt_q       <= '0;
            inflight_q      <= 1'b0;
            last_inflight_q <= 1'b0;
            r_addr_q        <= '0;
        end else begin
            state_q         <= state_d;
            sel_q           <= sel_d;
            row_q           <= row_d;
            flip_q          <= flip_d;
            col_cnt_q       <= col_cnt_d;
            inflight_q      <= inflight_d;
            last_inflight_q <= last_inflight_d;
            r_addr_q        <= r_addr_d;
        end
    end

    sync_fifo_small #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(pix_entry_t))
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (abort),
        .push      (push),
        .push_data (entry_in),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count)
    );
endmodule

// File: tb/tb_sprite_row_reader.sv
// tb/tb_sprite_row_reader.sv - scoreboard bench for sprite_row_reader against a sprite memory model
module tb_sprite_row_reader;
    logic       clock = 1'b0;
    logic       reset, req_valid, req_ready, req_flip, abort;
    logic [3:0] req_select, r_select, r_data, pix_data;
    logic [4:0] req_row;
    logic [9:0] r_addr;
    logic       pix_valid, pix_ready, pix_last;

    logic [3:0] mem [16][1024];
    logic [4:0] exp_q [$];
    logic [4:0] mon_e;
    int n_checks = 0, n_pass = 0, n_pop = 0, cyc = 0, ready_mode = 3, max_addr = 0;

    sprite_row_reader dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_select(req_select), .req_row(req_row), .req_flip(req_flip), .abort(abort),
        .r_select(r_select), .r_addr(r_addr), .r_data(r_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last)
    );

    always #5 clock = ~clock;

    always @(posedge clock) r_data <= mem[r_select][r_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clock) begin
        if (reset === 1'b1 && pix_valid === 1'b1 && pix_ready === 1'b1) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("pix_data", 32'(pix_data), 32'(mon_e[4:1]));
                chk("pix_last", 32'(pix_last), 32'(mon_e[0]));
            end
            n_pop++;
        end
        if (reset === 1'b1 && int'(r_addr) > max_addr) max_addr = int'(r_addr);
    end

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        case (ready_mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            2:       pix_ready = 1'($urandom_range(0, 1));
            default: pix_ready = 1'b0;
        endcase
    endtask

    task automatic send(input int sel, input int row, input bit flip);
        int t = 0;
        req_valid = 1'b1; req_select = 4'(sel); req_row = 5'(row); req_flip = flip;
        while (!req_ready && t < 3000) begin step(); t++; end
        chk("req_accept_timeout", 32'(req_ready), 1);
        for (int i = 0; i < 32; i++) begin
            int col = flip ? 31 - i : i;
            exp_q.push_back({mem[sel][row * 32 + col], 1'(i == 31)});
        end
        step();
        req_valid = 1'b0;
        req_select = 4'($urandom); req_row = 5'($urandom); req_flip = 1'($urandom);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || pix_valid) && t < 2000) begin step(); t++; end
        chk(name, 32'(exp_q.size()), 0);
        chk({name, "_idle_valid"}, 32'(pix_valid), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 1);
        chk({tag, "_pix_valid"}, 32'(pix_valid), 0);
        chk({tag, "_pix_last"},  32'(pix_last), 0);
        chk({tag, "_r_addr"},    32'(r_addr), 0);
        chk({tag, "_r_select"},  32'(r_select), 0);
    endtask

    initial begin
        int base, t;
        for (int s = 0; s < 16; s++)
            for (int a = 0; a < 1024; a++) mem[s][a] = 4'($urandom);
        reset = 1'b0; req_valid = 1'b0; req_select = '0; req_row = '0; req_flip = 1'b0;
        abort = 1'b0; pix_ready = 1'b0;
        step(); step();
        chk_reset_outputs("reset");
        reset = 1'b1;
        ready_mode = 0;
        step();

        // forward row: consecutive addresses and two-cycle first-pixel latency
        send(3, 5, 0);
        for (int i = 0; i < 32; i++) begin
            chk("fwd_r_addr", 32'(r_addr), 32'(160 + i));
            if (i == 0) chk("fwd_r_select", 32'(r_select), 3);
            if (i == 1) chk("fwd_latency_early", 32'(pix_valid), 0);
            if (i == 2) chk("fwd_latency_first", 32'(pix_valid), 1);
            step();
        end
        drain("fwd_drain");

        // mirrored row
        send(0, 0, 1);
        for (int i = 0; i < 32; i++) begin
            chk("mir_r_addr", 32'(r_addr), 32'(31 - i));
            step();
        end
        drain("mir_drain");

        // backpressure 1,0,0,1
        ready_mode = 1;
        send(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)), 0);
        drain("bp_fwd_drain");
        send(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)), 1);
        drain("bp_mir_drain");

        // abort after 10 accepted pixels
        ready_mode = 0;
        base = n_pop;
        send(7, 9, 0);
        t = 0;
        while (n_pop - base < 10 && t < 200) begin step(); t++; end
        chk("abort_wait_timeout", 32'(n_pop - base >= 10), 1);
        abort = 1'b1; pix_ready = 1'b0;
        exp_q.delete();
        step();
        abort = 1'b0;
        chk("abort_pix_valid", 32'(pix_valid), 0);
        chk("abort_req_ready", 32'(req_ready), 1);
        chk("abort_pix_last",  32'(pix_last), 0);
        send(2, 17, 0);
        drain("post_abort_drain");

        // abort in IDLE together with a request: not accepted
        req_valid = 1'b1; req_select = 4'd9; abort = 1'b1;
        step();
        req_valid = 1'b0; abort = 1'b0;
        chk("idle_abort_req_ready", 32'(req_ready), 1);
        chk("idle_abort_r_select", 32'(r_select), 2);
        step(); step(); step();
        chk("idle_abort_no_pixel", 32'(pix_valid), 0);

        // reset mid-row with the FIFO full
        ready_mode = 3;
        send(5, 12, 1);
        for (int i = 0; i < 6; i++) step();
        chk("fifo_full_valid", 32'(pix_valid), 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        exp_q.delete();
        chk_reset_outputs("midrow_reset");
        ready_mode = 0;
        step();
        send(4, 3, 0);
        chk("post_reset_col0", 32'(r_addr), 96);
        drain("post_reset_drain");

        // random rows under random backpressure
        ready_mode = 2;
        for (int k = 0; k < 6; k++)
            send(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)), 1'($urandom));
        drain("rand_drain");

        // back-to-back rows reaching the top address
        ready_mode = 0;
        max_addr = 0;
        send(15, 31, 0);
        send(1, 0, 0);
        drain("b2b_drain");
        chk("b2b_max_addr", 32'(max_addr), 1023);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
